// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and 8N1 frame constants.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } uart_state_e;

endpackage

// File: rtl/baud_tick.sv
// Oversampling baud divider: one-cycle tick every FREQ_IN/(FREQ_OUT*OVERSAMPLE) hclk.
// clr restarts the count so the first tick lands a full period later.
module baud_tick #(
  parameter int unsigned FREQ_IN    = 12000000,
  parameter int unsigned FREQ_OUT   = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic hclk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned Div  = FREQ_IN / (FREQ_OUT * OVERSAMPLE);
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: wrap at Div-1, restart on clr.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || (cnt_q == CntLast)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge hclk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == CntLast);

endmodule

// File: rtl/uart_rx_8n1.sv
// UART 8N1 receiver: 2-flop synchroniser, mid-bit sampling FSM, byte/strobe outputs.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int unsigned FREQ_IN    = 12000000,
  parameter int unsigned FREQ_OUT   = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       hclk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       rx_error,
  output logic       rx_busy
);

  localparam int unsigned SampleW = $clog2(OVERSAMPLE);
  localparam logic [SampleW-1:0] MidStart = SampleW'(OVERSAMPLE / 2 - 1);
  localparam logic [SampleW-1:0] MidBit   = SampleW'(OVERSAMPLE - 1);
  localparam logic [2:0] LastBit = 3'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic                 rx_meta_q, rx_s_q;
  logic [SampleW-1:0]   sample_cnt_q, sample_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [7:0]           rx_data_q, rx_data_d;
  logic                 ready_q, ready_d;
  logic                 error_q, error_d;
  logic                 tick;
  logic                 tick_clr;

  baud_tick #(
    .FREQ_IN   (FREQ_IN),
    .FREQ_OUT  (FREQ_OUT),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud_tick (
    .hclk(hclk),
    .rst (rst),
    .clr (tick_clr),
    .tick(tick)
  );

  // State, counters, synchroniser and output registers.
  always_ff @(posedge hclk) begin
    if (rst) begin
      state_q      <= StIdle;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      rx_data_q    <= 8'h00;
      ready_q      <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      rx_data_q    <= rx_data_d;
      ready_q      <= ready_d;
      error_q      <= error_d;
    end
  end

  // Next-state and sample/bit counter sequencing.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    tick_clr     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d      = StStart;
          sample_cnt_d = '0;
          tick_clr     = 1'b1;
        end
      end
      StStart: begin
        if (tick) begin
          if (sample_cnt_q == MidStart) begin
            sample_cnt_d = '0;
            bit_cnt_d    = '0;
            // High at mid start bit is a glitch, not a frame.
            state_d      = rx_s_q ? StIdle : StData;
          end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (sample_cnt_q == MidBit) begin
            sample_cnt_d = '0;
            bit_cnt_d    = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LastBit) begin
              state_d = StStop;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (sample_cnt_q == MidBit) begin
            sample_cnt_d = '0;
            state_d      = rx_s_q ? StIdle : StBreak;
          end else begin
            sample_cnt_d = sample_cnt_q + 1'b1;
          end
        end
      end
      StBreak: begin
        // Hold off until the line returns high so a stuck-low line cannot retrigger.
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Shift register, output byte and strobes.
  always_comb begin
    shreg_d   = shreg_q;
    rx_data_d = rx_data_q;
    ready_d   = 1'b0;
    error_d   = 1'b0;
    if ((state_q == StData) && tick && (sample_cnt_q == MidBit)) begin
      shreg_d = {rx_s_q, shreg_q[DATA_BITS-1:1]};
    end
    if ((state_q == StStop) && tick && (sample_cnt_q == MidBit)) begin
      if (rx_s_q) begin
        rx_data_d = shreg_q;
        ready_d   = 1'b1;
      end else begin
        error_d = 1'b1;
      end
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_ready = ready_q;
  assign rx_error = error_q;
  assign rx_busy  = (state_q != StIdle);

endmodule
